// File: rtl/rgb_led_bargraph_frame_loader.sv
// rgb_led_bargraph_frame_loader
//
// Takes a valid/ready pixel byte stream and writes one full frame
// (2**ROW_BITS rows x 2**COL_BITS cols, row-major) into the back half of the
// bargraph driver's display RAM. After the last pixel has been written it
// flips buffer_select. It then waits for the driver to report the same
// buffer on buffer_current before it accepts the next frame. Because of this,
// the driver never scans a half-written frame.
//
// Optional feature: define RGB_LED_BARGRAPH_GAMMA_EN to insert one pipeline
// stage that applies wr_data = (d*(d+1)) >> 8. This makes the write latency
// 2 cycles instead of 1.
//
// Ports
//   clk             in   clock, shared with the driver and its RAM write port
//   rst_n           in   synchronous active-low reset
//   s_valid         in   pixel beat valid
//   s_ready         out  beat accepted when s_valid & s_ready
//   s_sof           in   beat is pixel 0 of a frame
//   s_data[7:0]     in   pixel level
//   wr              out  RAM write strobe
//   wr_addr[8:0]    out  {buffer, row, col}
//   wr_data[7:0]    out  pixel level to the RAM
//   buffer_select   out  buffer the driver should display
//   buffer_current  in   buffer the driver is displaying
//   frame_done      out  1-cycle pulse when a swap is confirmed
//   sync_err        out  1-cycle pulse on a dropped beat or a frame restart
module rgb_led_bargraph_frame_loader #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         s_sof,
  input  logic [7:0]                   s_data,
  output logic                         wr,
  output logic [ROW_BITS+COL_BITS:0]   wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         buffer_select,
  input  logic                         buffer_current,
  output logic                         frame_done,
  output logic                         sync_err
);

  localparam int PIX_BITS = ROW_BITS + COL_BITS;
  localparam logic [PIX_BITS-1:0] LAST_PIX  = '1;
  localparam logic [PIX_BITS-1:0] FIRST_PIX = '0;
  localparam logic [PIX_BITS-1:0] ONE_PIX   = PIX_BITS'(1);

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, SWAP, WAIT_SWAP} state_t;

  state_t              state_reg, state_next;
  logic [PIX_BITS-1:0] pix_cnt_reg, pix_cnt_next;
  logic                back_reg, back_next;
  logic                s_ready_next;
  logic                buffer_select_next;
  logic                frame_done_next;
  logic                sync_err_next;

  // Write request into the output pipeline (valid in the accepting cycle).
  logic                wr_en;
  logic [PIX_BITS:0]   wr_addr_in;
  // High while a write is still inside the pipeline and not yet on wr.
  logic                pipe_busy;

  logic                accept;
  assign accept = s_valid & s_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pix_cnt_reg   <= '0;
      back_reg      <= 1'b0;
      s_ready       <= 1'b0;
      buffer_select <= 1'b0;
      frame_done    <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pix_cnt_reg   <= pix_cnt_next;
      back_reg      <= back_next;
      s_ready       <= s_ready_next;
      buffer_select <= buffer_select_next;
      frame_done    <= frame_done_next;
      sync_err      <= sync_err_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next         = state_reg;
    pix_cnt_next       = pix_cnt_reg;
    back_next          = back_reg;
    buffer_select_next = buffer_select;
    frame_done_next    = 1'b0;
    sync_err_next      = 1'b0;
    wr_en              = 1'b0;
    wr_addr_in         = {back_reg, pix_cnt_reg};

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (s_sof) begin
            // back_reg is not valid yet in this cycle, so the first write
            // addresses the new back buffer directly.
            back_next    = ~buffer_select;
            wr_en        = 1'b1;
            wr_addr_in   = {~buffer_select, FIRST_PIX};
            pix_cnt_next = ONE_PIX;
            state_next   = FILL;
          end else begin
            sync_err_next = 1'b1;
          end
        end
      end

      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (s_sof) begin
            // Restart in the same back buffer. The buffer is not captured
            // again, so a frame never spills into the displayed half.
            wr_addr_in    = {back_reg, FIRST_PIX};
            pix_cnt_next  = ONE_PIX;
            sync_err_next = 1'b1;
          end else begin
            wr_addr_in   = {back_reg, pix_cnt_reg};
            pix_cnt_next = pix_cnt_reg + 1'b1;
            if (pix_cnt_reg == LAST_PIX) begin
              state_next = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        if (!pipe_busy) begin
          state_next = SWAP;
        end
      end

      SWAP: begin
        buffer_select_next = back_reg;
        state_next         = WAIT_SWAP;
      end

      WAIT_SWAP: begin
        if (buffer_current == buffer_select) begin
          frame_done_next = 1'b1;
          state_next      = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    s_ready_next = (state_next == IDLE) || (state_next == FILL);
  end

  // --------------------------------------------------------------------------
  // Write pipeline
  // --------------------------------------------------------------------------
`ifdef RGB_LED_BARGRAPH_GAMMA_EN
  logic              pipe_valid_reg;
  logic [PIX_BITS:0] pipe_addr_reg;
  logic [7:0]        pipe_data_reg;
  logic [15:0]       gamma_prod;

  // 255*256 = 65280 still fits in 16 bits, so the top byte is always exact.
  assign gamma_prod = {8'd0, pipe_data_reg} * ({8'd0, pipe_data_reg} + 16'd1);
  assign pipe_busy  = pipe_valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid_reg <= 1'b0;
      pipe_addr_reg  <= '0;
      pipe_data_reg  <= '0;
      wr             <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
    end else begin
      pipe_valid_reg <= wr_en;
      if (wr_en) begin
        pipe_addr_reg <= wr_addr_in;
        pipe_data_reg <= s_data;
      end
      wr <= pipe_valid_reg;
      if (pipe_valid_reg) begin
        wr_addr <= pipe_addr_reg;
        wr_data <= 8'(gamma_prod >> 8);
      end
    end
  end
`else
  // With a single stage, the final write is on wr during the first DRAIN cycle.
  assign pipe_busy = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr      <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr <= wr_en;
      if (wr_en) begin
        wr_addr <= wr_addr_in;
        wr_data <= s_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rgb_led_bargraph_frame_loader.sv
// Testbench for rgb_led_bargraph_frame_loader.
// A driver stub echoes buffer_select onto buffer_current 10 cycles after a
// change, or holds buffer_current when stub_hold is set. Expected writes are
// queued as beats are accepted, and a negedge monitor compares them with
// each wr pulse, including the write latency.
module tb_rgb_led_bargraph_frame_loader;

`ifdef RGB_LED_BARGRAPH_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic       s_sof;
  logic [7:0] s_data;
  logic       wr;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       buffer_select;
  logic       buffer_current;
  logic       frame_done;
  logic       sync_err;

  rgb_led_bargraph_frame_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_sof          (s_sof),
    .s_data         (s_data),
    .wr             (wr),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .buffer_select  (buffer_select),
    .buffer_current (buffer_current),
    .frame_done     (frame_done),
    .sync_err       (sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference gamma curve: (d*(d+1)) >> 8 when enabled, identity otherwise.
  function automatic logic [7:0] exp_pix(input logic [7:0] d);
`ifdef RGB_LED_BARGRAPH_GAMMA_EN
    logic [15:0] p;
    p = {8'd0, d} * ({8'd0, d} + 16'd1);
    return p[15:8];
`else
    return d;
`endif
  endfunction

  // ---------------------------------------------------------------- cycle count
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- driver stub
  logic stub_hold = 1'b0;
  int   stub_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      buffer_current <= 1'b0;
      stub_cnt       <= 0;
    end else if (buffer_select !== buffer_current && !stub_hold) begin
      if (stub_cnt == 9) begin
        buffer_current <= buffer_select;
        stub_cnt       <= 0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end else begin
      stub_cnt <= 0;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
    int         stamp;
  } wr_exp_t;

  wr_exp_t sb[$];
  wr_exp_t sb_e;
  int      wr_seen   = 0;
  int      sync_cnt  = 0;
  int      done_cnt  = 0;
  int      sel_flips = 0;
  logic    sel_prev  = 1'b0;

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wr_seen++;
      if (sb.size() == 0) begin
        check("unexpected_wr", 32'(wr), 32'd0);
      end else begin
        sb_e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(sb_e.addr));
        check("wr_data", 32'(wr_data), 32'(sb_e.data));
        check("wr_latency", 32'(cyc), 32'(sb_e.stamp));
        check("wr_buf_vs_current", 32'(wr_addr[8] ^ buffer_current), 32'd1);
      end
      $display("wr  addr=0x%03h data=0x%02h cyc=%0d", wr_addr, wr_data, cyc);
    end
    if (sync_err === 1'b1) sync_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    if (buffer_select !== sel_prev) begin
      sel_flips++;
      sel_prev = buffer_select;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic send_beat(input logic sof, input logic [7:0] data,
                           input logic exp_wr, input logic [8:0] exp_addr,
                           input logic [7:0] exp_data);
    int n;
    wr_exp_t e;
    @(negedge clk);
    s_valid = 1'b1;
    s_sof   = sof;
    s_data  = data;
    n = 0;
    while (s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      check("beat_accept_timeout", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
      return;
    end
    if (exp_wr) begin
      e.addr  = exp_addr;
      e.data  = exp_data;
      e.stamp = cyc + LAT;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic stop_stream();
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [8:0] base);
    for (int i = 0; i < 256; i++) begin
      send_beat(i == 0, 8'(i), 1'b1, base + 9'(i), exp_pix(8'(i)));
    end
    stop_stream();
    check("s_ready_after_last", 32'(s_ready), 32'd0);
  endtask

  task automatic wait_frame_done(input int budget);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_done", 32'(frame_done), 32'd1);
    $display("frame_done cyc=%0d buffer_select=%0b", cyc, buffer_select);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_wr"}, 32'(wr), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_buffer_select"}, 32'(buffer_select), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int wr0, sync0, flips0, done0, bad;
    logic [7:0] din, dexp;
    logic [7:0] tbl_in [4];
    logic [7:0] tbl_out [4];
    tbl_in = '{8'd0, 8'd16, 8'd128, 8'd255};
`ifdef RGB_LED_BARGRAPH_GAMMA_EN
    tbl_out = '{8'd0, 8'd1, 8'd64, 8'd255};
`else
    tbl_out = '{8'd0, 8'd16, 8'd128, 8'd255};
`endif

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = 8'd0;

    // Reset state and s_ready rising one cycle after release.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_reset", 32'(s_ready), 32'd1);

    // Frame 1: back buffer 1.
    send_frame(9'h100);
    wait_frame_done(200);
    check("frame1_buffer_select", 32'(buffer_select), 32'd1);
    check("frame1_sb_empty", 32'(sb.size()), 32'd0);

    // Frame 2: back buffer 0.
    send_frame(9'h000);
    wait_frame_done(200);
    check("frame2_buffer_select", 32'(buffer_select), 32'd0);
    check("frame2_sb_empty", 32'(sb.size()), 32'd0);

    // Five beats without sof in IDLE are dropped.
    wr0   = wr_seen;
    sync0 = sync_cnt;
    for (int i = 0; i < 5; i++) send_beat(1'b0, 8'(8'hA0 + i), 1'b0, 9'd0, 8'd0);
    stop_stream();
    repeat (4) @(negedge clk);
    check("nosof_sync_err_count", 32'(sync_cnt - sync0), 32'd5);
    check("nosof_no_wr", 32'(wr_seen - wr0), 32'd0);
    check("nosof_still_idle_ready", 32'(s_ready), 32'd1);

    // Restart on beat 100: written at 0x100, then 255 more beats finish the frame.
    sync0  = sync_cnt;
    flips0 = sel_flips;
    for (int i = 0; i < 100; i++) begin
      send_beat(i == 0, 8'(i), 1'b1, 9'h100 + 9'(i), exp_pix(8'(i)));
    end
    send_beat(1'b1, 8'd100, 1'b1, 9'h100, exp_pix(8'd100));
    for (int j = 1; j < 256; j++) begin
      din = 8'(j + 100);
      send_beat(1'b0, din, 1'b1, 9'h100 + 9'(j), exp_pix(din));
    end
    stop_stream();
    wait_frame_done(200);
    check("restart_sync_err_count", 32'(sync_cnt - sync0), 32'd1);
    check("restart_single_flip", 32'(sel_flips - flips0), 32'd1);
    check("restart_buffer_select", 32'(buffer_select), 32'd1);
    check("restart_sb_empty", 32'(sb.size()), 32'd0);

    // Driver holds buffer_current: no ready, no writes, no frame_done.
    stub_hold = 1'b1;
    send_frame(9'h000);
    repeat (5) @(negedge clk);
    check("hold_buffer_select", 32'(buffer_select), 32'd0);
    wr0   = wr_seen;
    done0 = done_cnt;
    bad   = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (s_ready !== 1'b0) bad++;
    end
    check("hold_s_ready_low_cycles", 32'(bad), 32'd0);
    check("hold_no_wr", 32'(wr_seen - wr0), 32'd0);
    check("hold_no_frame_done", 32'(done_cnt - done0), 32'd0);
    stub_hold = 1'b0;
    wait_frame_done(50);
    @(negedge clk);
    check("release_s_ready", 32'(s_ready), 32'd1);
    check("hold_sb_empty", 32'(sb.size()), 32'd0);

    // Frame with the gamma reference points as its first pixels.
    for (int i = 0; i < 256; i++) begin
      din  = (i < 4) ? tbl_in[i]  : 8'(i);
      dexp = (i < 4) ? tbl_out[i] : exp_pix(8'(i));
      send_beat(i == 0, din, 1'b1, 9'h100 + 9'(i), dexp);
    end
    stop_stream();
    wait_frame_done(200);
    check("frame5_buffer_select", 32'(buffer_select), 32'd1);
    check("frame5_sb_empty", 32'(sb.size()), 32'd0);

    // Reset at beat 50 of a frame.
    for (int i = 0; i < 50; i++) begin
      send_beat(i == 0, 8'(i), 1'b1, 9'h000 + 9'(i), exp_pix(8'(i)));
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_s_ready", 32'(s_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
